// File: rtl/fmul_requester.sv
// rtl/fmul_requester.sv - tagged request/response front end for the handshake FP multiplier
module fmul_requester #(
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    // request port from the execute stage
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [TAG_W-1:0] req_tag,
    // multiplier operand side
    output logic [63:0]      input_mul,
    output logic             input_mul_stb,
    input  logic             s_input_mul_ack,
    // multiplier result side
    input  logic [31:0]      z,
    input  logic             s_output_z_stb,
    // response port to the consumer
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err
);

    // Quiet NaN returned when the multiplier never accepts or never answers.
    localparam logic [31:0] ABORT_DATA = 32'h7fc0_0000;
    // Last watchdog count before the abort is taken.
    localparam logic [7:0]  WD_LAST    = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [63:0]        op_q, op_d;          // {a, b} as presented to the multiplier
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [7:0]         wd_cnt_q, wd_cnt_d;
    logic [31:0]        data_q, data_d;
    logic               err_q, err_d;

    logic               wd_expired;
    logic               req_ready_c;
    logic               stb_c;
    logic               rsp_valid_c;

    assign wd_expired = (wd_cnt_q == WD_LAST);

    // Next-state and handshake decode; every output gets a safe default first.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        tag_d       = tag_q;
        wd_cnt_d    = wd_cnt_q;
        data_d      = data_q;
        err_d       = err_q;
        req_ready_c = 1'b0;
        stb_c       = 1'b0;
        rsp_valid_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                req_ready_c = 1'b1;
                if (req_valid) begin
                    op_d     = {req_a, req_b};
                    tag_d    = req_tag;
                    wd_cnt_d = 8'd0;
                    state_d  = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                // The strobe follows ack combinationally so it is never raised
                // while the multiplier is busy or coming out of its own reset.
                stb_c    = s_input_mul_ack;
                wd_cnt_d = wd_cnt_q + 8'd1;
                if (s_input_mul_ack) begin
                    wd_cnt_d = 8'd0;
                    state_d  = ST_WAIT;
                end else if (wd_expired) begin
                    data_d  = ABORT_DATA;
                    err_d   = 1'b1;
                    state_d = ST_HOLD;
                end
            end

            ST_WAIT: begin
                wd_cnt_d = wd_cnt_q + 8'd1;
                // A result on the expiry edge takes priority over the abort.
                if (s_output_z_stb) begin
                    data_d  = z;
                    err_d   = 1'b0;
                    state_d = ST_HOLD;
                end else if (wd_expired) begin
                    data_d  = ABORT_DATA;
                    err_d   = 1'b1;
                    state_d = ST_HOLD;
                end
            end

            ST_HOLD: begin
                rsp_valid_c = 1'b1;
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers, all cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= 64'd0;
            tag_q    <= '0;
            wd_cnt_q <= 8'd0;
            data_q   <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            tag_q    <= tag_d;
            wd_cnt_q <= wd_cnt_d;
            data_q   <= data_d;
            err_q    <= err_d;
        end
    end

    // Handshake outputs are forced low while reset is held so nothing is
    // offered or accepted before the state register has been initialised.
    assign req_ready     = req_ready_c & ~rst;
    assign input_mul_stb = stb_c & ~rst;
    assign rsp_valid     = rsp_valid_c & ~rst;

    assign input_mul = op_q;
    assign rsp_data  = data_q;
    assign rsp_tag   = tag_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_fmul_requester.sv
// tb/tb_fmul_requester.sv - scoreboard bench for fmul_requester with a stub multiplier
module tb_fmul_requester;

    localparam int TAG_W = 4;
    localparam int TO    = 16;
    localparam logic [31:0] QNAN = 32'h7fc00000;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [31:0]      req_a = 32'd0;
    logic [31:0]      req_b = 32'd0;
    logic [TAG_W-1:0] req_tag = '0;
    logic [63:0]      input_mul;
    logic             input_mul_stb;
    logic             s_input_mul_ack;
    logic [31:0]      z;
    logic             s_output_z_stb;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [31:0]      rsp_data;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
        logic             err;
    } rsp_t;
    rsp_t exp_q[$];

    always #5 clk = ~clk;

    fmul_requester #(.TAG_W(TAG_W), .TIMEOUT(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_a          (req_a),
        .req_b          (req_b),
        .req_tag        (req_tag),
        .input_mul      (input_mul),
        .input_mul_stb  (input_mul_stb),
        .s_input_mul_ack(s_input_mul_ack),
        .z              (z),
        .s_output_z_stb (s_output_z_stb),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .rsp_tag        (rsp_tag),
        .rsp_err        (rsp_err)
    );

    // Product table for the named operand pairs; other pairs get a stand-in
    // value so the pass-through of arbitrary bit patterns is exercised.
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h40000000 && b == 32'h40400000) return 32'h40c00000;
        if (a == 32'h3fc00000 && b == 32'hc0800000) return 32'hc0c00000;
        return a ^ {b[15:0], b[31:16]} ^ 32'h5a5a5a5a;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Stub multiplier: ack low while busy or before ack_release, result after result_delay cycles.
    int cyc = 0;
    int stub_d = 0;
    int result_delay = 3;
    int ack_release = 0;
    logic [63:0] stub_op = 64'd0;

    always @(posedge clk) cyc <= cyc + 1;

    assign s_input_mul_ack = (stub_d == 0) && (cyc >= ack_release);
    assign s_output_z_stb  = (stub_d != 0) && (stub_d == result_delay);
    assign z               = ref_mul(stub_op[63:32], stub_op[31:0]);

    always @(posedge clk) begin
        if (input_mul_stb && s_input_mul_ack) begin
            stub_op <= input_mul;
            stub_d  <= 1;
        end else if (stub_d != 0) begin
            stub_d <= (stub_d == result_delay) ? 0 : stub_d + 1;
        end
    end

    // Monitor: pops the scoreboard whenever a response is consumed.
    always @(negedge clk) begin
        rsp_t e;
        if (!rst) begin
            if (input_mul_stb) check("strobe_needs_ack", s_input_mul_ack, 1'b1);
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_response: got data %0h tag %0h err %0b, required none",
                             rsp_data, rsp_tag, rsp_err);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_data", rsp_data, e.data);
                    check("rsp_tag", rsp_tag, e.tag);
                    check("rsp_err", rsp_err, e.err);
                end
            end
        end
    end

    // One request from acceptance to consumption; timing is checked against
    // the cycle numbers implied by ack hold-off, result delay and watchdog.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] tag,
                          input int hold, input int rdel, input int rdy_delay);
        int exp_stb, exp_vld, stb_cyc, vld_cyc, stb_cnt, rdy_cnt, budget;
        bit done, op_ok, hold_ok, rdyq_ok;
        logic [31:0] exp_data;
        logic exp_err;
        logic [31:0] snap_data;
        logic [TAG_W-1:0] snap_tag;
        logic snap_err;
        rsp_t e;

        if (hold > TO - 1) begin
            exp_stb = -1; exp_vld = 1 + TO; exp_data = QNAN; exp_err = 1'b1;
        end else if (rdel <= TO) begin
            exp_stb = 1 + hold; exp_vld = 2 + hold + rdel; exp_data = ref_mul(a, b); exp_err = 1'b0;
        end else begin
            exp_stb = 1 + hold; exp_vld = 2 + hold + TO; exp_data = QNAN; exp_err = 1'b1;
        end

        result_delay = rdel;
        ack_release  = cyc + 1 + hold;
        req_a = a; req_b = b; req_tag = tag; req_valid = 1'b1;
        rsp_ready = (rdy_delay == 0);
        stb_cyc = -1; vld_cyc = -1; stb_cnt = 0; rdy_cnt = 0;
        done = 0; op_ok = 1; hold_ok = 1; rdyq_ok = 1;
        snap_data = '0; snap_tag = '0; snap_err = 1'b0;
        budget = 3 * TO + hold + rdy_delay + 20;

        for (int k = 0; k < budget && !done; k++) begin
            @(negedge clk);
            if (k == 0) check("req_ready_idle", req_ready, 1'b1);
            if (input_mul_stb) begin
                stb_cnt++;
                if (stb_cyc < 0) stb_cyc = k;
            end
            if (k >= 1 && !rsp_valid && (stb_cyc < 0 || stb_cyc == k) && input_mul !== {a, b})
                op_ok = 0;
            if (rsp_valid) begin
                if (vld_cyc < 0) begin
                    vld_cyc = k; snap_data = rsp_data; snap_tag = rsp_tag; snap_err = rsp_err;
                end else if (rsp_data !== snap_data || rsp_tag !== snap_tag || rsp_err !== snap_err) begin
                    hold_ok = 0;
                end
                if (req_ready !== 1'b0) rdyq_ok = 0;
                if (rsp_ready) done = 1;
            end
            @(posedge clk); #1;
            if (k == 0) begin
                req_valid = 1'b0;
                e.data = exp_data; e.tag = tag; e.err = exp_err;
                exp_q.push_back(e);
            end
            if (vld_cyc >= 0 && !done && rdy_delay > 0) begin
                rdy_cnt++;
                if (rdy_cnt >= rdy_delay) begin
                    rsp_ready = 1'b1; req_valid = 1'b0;
                end else begin
                    req_valid = 1'b1; req_tag = ~tag;
                end
            end
        end

        if (!done) begin
            n_checks++; n_fail++;
            $display("FAIL op_timeout: no response consumed within %0d cycles, required one", budget);
            req_valid = 1'b0; rsp_ready = 1'b1;
        end
        check("strobe_cycle", stb_cyc, exp_stb);
        check("strobe_count", stb_cnt, (exp_stb < 0) ? 0 : 1);
        check("valid_cycle", vld_cyc, exp_vld);
        check("operand_stable_in_issue", op_ok, 1'b1);
        check("response_stable_in_hold", hold_ok, 1'b1);
        check("req_ready_low_in_hold", rdyq_ok, 1'b1);
        @(negedge clk);
        check("idle_after_consume", req_ready, 1'b1);
        check("rsp_valid_dropped", rsp_valid, 1'b0);
        @(posedge clk); #1;
    endtask

    // Let the stub drain; any late result pulse must not produce a response.
    task automatic settle();
        bit quiet;
        quiet = 1;
        for (int i = 0; i < 4 * TO && stub_d != 0; i++) begin
            @(negedge clk);
            if (rsp_valid) quiet = 0;
            @(posedge clk); #1;
        end
        check("no_response_while_draining", quiet, 1'b1);
    endtask

    task automatic mid_reset();
        bit quiet;
        result_delay = 3;
        ack_release  = cyc + 1;
        req_a = 32'h40000000; req_b = 32'h40400000; req_tag = 4'h7;
        req_valid = 1'b1; rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("midrst_strobe", input_mul_stb, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_req_ready_in_reset", req_ready, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_idle", req_ready, 1'b1);
        check("midrst_rsp_valid", rsp_valid, 1'b0);
        check("midrst_rsp_data", rsp_data, 32'd0);
        check("midrst_input_mul", input_mul, 64'd0);
        quiet = 1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (rsp_valid) quiet = 0;
        end
        check("midrst_no_response", quiet, 1'b1);
        @(posedge clk); #1;
        run_op(32'h3fc00000, 32'hc0800000, 4'h9, 0, 3, 0);
        settle();
    endtask

    initial begin
        int h, rd, rdy;
        logic [31:0] ra, rb;
        logic [TAG_W-1:0] rt;

        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("reset_req_ready", req_ready, 1'b0);
        check("reset_input_mul_stb", input_mul_stb, 1'b0);
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_rsp_err", rsp_err, 1'b0);
        check("reset_rsp_data", rsp_data, 32'd0);
        check("reset_rsp_tag", rsp_tag, 0);
        check("reset_input_mul", input_mul, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("req_ready_after_reset", req_ready, 1'b1);
        @(posedge clk); #1;

        // basic multiply, then a back-to-back second op
        run_op(32'h40000000, 32'h40400000, 4'h5, 0, 3, 0);
        run_op(32'h3fc00000, 32'hc0800000, 4'h6, 0, 3, 0);
        settle();
        // backpressure for 10 cycles
        run_op(32'h40000000, 32'h40400000, 4'h3, 0, 3, 10);
        settle();
        // ack held low for 4 issue cycles
        run_op(32'h40000000, 32'h40400000, 4'h4, 4, 3, 0);
        settle();
        // watchdog in WAIT with a late pulse that lands in IDLE
        run_op(32'h12345678, 32'h9abcdef0, 4'ha, 0, TO + 4, 0);
        settle();
        // result coincides with expiry
        run_op(32'h0badf00d, 32'hcafef00d, 4'hb, 0, TO, 0);
        settle();
        // one cycle past expiry loses
        run_op(32'h0badf00d, 32'hcafef00d, 4'hc, 0, TO + 1, 0);
        settle();
        // watchdog while still in ISSUE; transfer on the last allowed cycle wins
        run_op(32'h11111111, 32'h22222222, 4'hd, TO + 2, 3, 0);
        settle();
        run_op(32'h33333333, 32'h44444444, 4'he, TO - 1, 3, 0);
        settle();
        // reset in WAIT
        mid_reset();

        for (int i = 0; i < 24; i++) begin
            h   = ($urandom_range(0, 4) == 0) ? $urandom_range(0, TO + 2) : $urandom_range(0, 3);
            rd  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, TO + 3) : 3;
            rdy = $urandom_range(0, 3);
            ra  = $urandom;
            rb  = $urandom;
            rt  = TAG_W'($urandom);
            run_op(ra, rb, rt, h, rd, rdy);
            settle();
        end

        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/fmul_requester.md
# fmul_requester

Initiator-side controller for the three-state single-precision multiplier handshake. It accepts tagged operand pairs from the CPU execute stage over a valid/ready port and issues them to the multiplier as the 64-bit `{a,b}` packed operand. It then waits for the multiplier's one-cycle result strobe and holds the result in a response register until the consumer takes it. A watchdog returns an error response if the multiplier never accepts or never answers.

## Interface
- `TAG_W`, default 4: width of the request/response tag.
- `TIMEOUT`, default 16: cycles allowed in ISSUE plus WAIT before abort; legal range 8..255.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted on an edge where `req_valid & req_ready`.
- `req_a` in 32: IEEE-754 operand a.
- `req_b` in 32: IEEE-754 operand b.
- `req_tag` in TAG_W: opaque tag, returned with the response.
- `input_mul` out 64: `{a[31:0], b[31:0]}` to the multiplier.
- `input_mul_stb` out 1: operand strobe to the multiplier.
- `s_input_mul_ack` in 1: multiplier idle/ready indication.
- `z` in 32: multiplier result.
- `s_output_z_stb` in 1: one-cycle result-valid pulse.
- `rsp_valid` out 1: response held.
- `rsp_ready` in 1: response consumed on an edge where `rsp_valid & rsp_ready`.
- `rsp_data` out 32: product, or `32'h7fc00000` on error.
- `rsp_tag` out TAG_W: tag of the originating request.
- `rsp_err` out 1: 1 means watchdog abort.

## Operation
- States: IDLE, ISSUE, WAIT, HOLD. Reset forces IDLE.
- IDLE:
  - `req_ready=1`.
  - On accept, register a, b and tag, clear `wd_cnt`, and go to ISSUE.
- ISSUE:
  - `input_mul` is driven from the operand register and is stable throughout.
  - `input_mul_stb = s_input_mul_ack`, gated combinationally, so a strobe is never raised while ack is low. This covers ack=0 for one cycle after multiplier reset and during its multiply/put_z/first-get cycles.
  - A transfer occurs on an edge with `input_mul_stb=1`; then clear `wd_cnt` and go to WAIT.
- WAIT:
  - `input_mul_stb=0`.
  - On `s_output_z_stb=1`, capture `rsp_data<=z` and `rsp_err<=0`, then go to HOLD.
- Watchdog:
  - `wd_cnt` (8-bit) increments each cycle in ISSUE and WAIT.
  - When `wd_cnt==TIMEOUT-1` and no transfer or result occurs that edge, load `rsp_data<=32'h7fc00000` and `rsp_err<=1`, then go to HOLD.
  - If a result strobe and expiry coincide, the result wins (`rsp_err=0`).
- HOLD:
  - `rsp_valid=1`; `rsp_data`, `rsp_tag` and `rsp_err` stay stable.
  - `rsp_valid & rsp_ready` returns to IDLE.
  - `req_ready=0` in HOLD; there is no same-cycle refill.
- `s_output_z_stb` outside WAIT is ignored. This covers late results after an abort and spurious pulses.
- The result is passed through bit-exact. No rounding or special-case handling is done here.
- Reset mid-operation:
  - Return to IDLE and drop the in-flight request.
  - Any result still in flight from the multiplier is ignored because the block is not in WAIT.

## Timing
- Reset values: `req_ready=0` while `rst=1`, then 1 from the first cycle after reset. `input_mul_stb=0`, `rsp_valid=0`, `rsp_err=0`, `rsp_data=0`, `rsp_tag=0`, `input_mul=0`.
- Nominal latency with the multiplier idle (ack=1) is 5 cycles:
  - cycle 0: request accepted.
  - cycle 1: ISSUE and transfer.
  - cycles 2–3: multiplier multiply and put_z.
  - cycle 4: `s_output_z_stb`.
  - cycle 5: `rsp_valid=1`.
- Back-to-back throughput is one op per 6 cycles with `rsp_ready` tied high. The next issue waits in ISSUE until the multiplier ack returns.
- `input_mul_stb` is high for exactly one cycle per transfer.

## Test plan
- Basic multiply: a=`32'h40000000` (2.0), b=`32'h40400000` (3.0), tag=5, `rsp_ready=1`. Require one strobe at cycle 1, `rsp_valid` at cycle 5, `rsp_data=32'h40c00000`, tag 5, err 0.
- Backpressure: hold `rsp_ready=0` for 10 cycles after `rsp_valid`. Require data/tag stable, `req_ready=0`, a new `req_valid` not accepted, and IDLE one cycle after `rsp_ready` rises.
- Ack gating: hold `s_input_mul_ack=0` for 4 cycles in ISSUE. Require `input_mul_stb=0` throughout, with the strobe on the first ack=1 cycle and `input_mul=64'h40000000_40400000` unchanged.
- Watchdog: with a stub multiplier that never pulses `s_output_z_stb`, require `rsp_err=1` and `rsp_data=32'h7fc00000` at exactly TIMEOUT cycles after entering WAIT. A late z pulse in IDLE produces no response.
- Coincidence: a z pulse on the expiry cycle gives `rsp_err=0` and `rsp_data=z`.
- Mid-op reset: assert `rst` in WAIT. Require `rsp_valid=0` and IDLE, no response when the multiplier's pulse arrives, and a following 1.5×−4.0 (`32'h3fc00000`, `32'hc0800000`) returning `32'hc0c00000`.
